mcu_playlist: RTL and testbench

- Parametrised successor to the music-player control unit.
- Sequences a playlist of NUM_SONGS songs.
- Handles play/pause, next, previous and song completion, with selectable playback mode and optional shuffle.
- Sits between the debounced/one-pulsed button inputs and the song_reader/note player.
- Drives the current song index, the play enable and a one-cycle player reset on every song change.

---
 rtl/mcu_pkg.sv | 19 +
 rtl/mcu_playlist_if.sv | 27 ++
 rtl/dffr.sv | 18 +
 rtl/mcu_playlist_lfsr8.sv | 25 ++
 rtl/mcu_playlist.sv | 95 +++++++++
 tb/tb_mcu_playlist.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the playlist controller and its shuffle generator.
// Holds the FSM state type, playback mode encodings and the LFSR feedback taps.
package mcu_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        SWITCH  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SEQ         = 2'd0;
    localparam logic [1:0] MODE_REPEAT_ONE  = 2'd1;
    localparam logic [1:0] MODE_STOP_AT_END = 2'd2;
    localparam logic [1:0] MODE_SHUFFLE     = 2'd3;

    // x^8 + x^6 + x^5 + x^4 + 1, expressed as a mask over q[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/mcu_playlist_if.sv
// Button/status bundle between the button conditioning logic and the playlist controller.
// master drives the pulses and mode; slave is the controller driving play, reset_player and song.
interface mcu_playlist_if #(
    parameter int NUM_SONGS = 4
);
    localparam int SONG_W = $clog2(NUM_SONGS);

    logic              play_button;
    logic              next_button;
    logic              prev_button;
    logic [1:0]        mode;
    logic              song_done;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;

    modport master (
        output play_button, next_button, prev_button, mode, song_done,
        input  play, reset_player, song
    );

    modport slave (
        input  play_button, next_button, prev_button, mode, song_done,
        output play, reset_player, song
    );

endinterface

// File: rtl/dffr.sv
// Plain register with asynchronous active-high reset to a parameterised value.
// Latency: one cycle, d to q. No backpressure.
module dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= RST_VAL;
        else       q <= d;
    end

endmodule

// File: rtl/mcu_playlist_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR feeding the shuffle target, free-running every cycle.
// Latency: new value each cycle after reset release. No backpressure.
module lfsr8
    import mcu_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] d;

    // A nonzero seed never reaches the all-zero lock-up state.
    assign d = {q[6:0], ^(q & LFSR_TAPS)};

    dffr #(.W(8), .RST_VAL(SEED)) u_q (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

endmodule

// File: rtl/mcu_playlist.sv
// mcu_playlist: playlist sequencer (play/pause, next/prev, song_done, mode); shuffle under MCU_PLAYLIST_SHUFFLE_EN.
// Latency: event sampled in cycle N shows on registered outputs in cycle N+1; SWITCH lasts one cycle.
// Backpressure: none; inputs are one-cycle pulses and anything arriving during SWITCH is dropped.
module mcu_playlist
    import mcu_pkg::*;
#(
    parameter int         NUM_SONGS = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic           clk,
    input  logic           reset,
    mcu_playlist_if.slave  pl
);

    localparam int                SONG_W = $clog2(NUM_SONGS);
    localparam logic [SONG_W-1:0] LAST   = SONG_W'(NUM_SONGS - 1);

    state_t            state, nxt_state;
    logic              run, nxt_run;
    logic              play_q, rp_q;
    logic [SONG_W-1:0] song_q, nxt_song;
    logic [SONG_W-1:0] inc_song, dec_song, adv_song;

    assign inc_song = (song_q == LAST) ? '0   : song_q + 1'b1;
    assign dec_song = (song_q == '0)   ? LAST : song_q - 1'b1;

`ifdef MCU_PLAYLIST_SHUFFLE_EN
    logic [7:0]        lfsr_q;
    logic [SONG_W:0]   cand_wide;
    logic [SONG_W-1:0] cand, shuf_song;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Folding SONG_W bits once into range is enough: 2^SONG_W < 2*NUM_SONGS.
    assign cand_wide = {1'b0, lfsr_q[SONG_W-1:0]};
    assign cand      = (cand_wide >= (SONG_W+1)'(NUM_SONGS))
                     ? SONG_W'(cand_wide - (SONG_W+1)'(NUM_SONGS))
                     : lfsr_q[SONG_W-1:0];
    assign shuf_song = (cand == song_q) ? inc_song : cand;
    assign adv_song  = (pl.mode == MODE_SHUFFLE) ? shuf_song : inc_song;
`else
    assign adv_song  = inc_song;
`endif

    always_comb begin
        nxt_state = state;
        nxt_song  = song_q;
        nxt_run   = run;
        if (state == SWITCH) begin
            nxt_state = run ? PLAYING : PAUSED;
        end else if (pl.next_button ^ pl.prev_button) begin
            nxt_state = SWITCH;
            nxt_song  = pl.next_button ? adv_song : dec_song;
            nxt_run   = (state == PLAYING) ^ pl.play_button;
        end else if (state == PLAYING && pl.song_done) begin
            nxt_state = SWITCH;
            nxt_run   = ~pl.play_button;
            case (pl.mode)
                MODE_REPEAT_ONE:  nxt_song = song_q;
                MODE_STOP_AT_END: begin
                    nxt_song = inc_song;
                    if (song_q == LAST) nxt_run = 1'b0;
                end
                default:          nxt_song = adv_song;
            endcase
        end else if (pl.play_button) begin
            nxt_state = (state == PLAYING) ? PAUSED : PLAYING;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PAUSED;
            song_q <= '0;
            run    <= 1'b0;
            play_q <= 1'b0;
            rp_q   <= 1'b0;
        end else begin
            state  <= nxt_state;
            song_q <= nxt_song;
            run    <= nxt_run;
            play_q <= (nxt_state == PLAYING);
            rp_q   <= (nxt_state == SWITCH);
        end
    end

    assign pl.play         = play_q;
    assign pl.reset_player = rp_q;
    assign pl.song         = song_q;

endmodule

// File: tb/tb_mcu_playlist.sv
// Randomised and directed bench for mcu_playlist against a song-level reference model.
module tb_mcu_playlist;
    localparam int N = 4;
    localparam int W = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcu_playlist_if #(.NUM_SONGS(N)) bus ();

    mcu_playlist #(.NUM_SONGS(N), .LFSR_SEED(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .pl    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = paused, 1 = playing, 2 = switching
    int         m_phase;
    int         m_song;
    bit         m_run;
    logic [7:0] m_lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int shuffle_pick(input int cur, input logic [7:0] r);
        int c;
        c = int'(r) % (1 << W);
        if (c >= N) c = c - N;
        if (c == cur) c = (cur + 1) % N;
        return c;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_song = 0; m_run = 1'b0; m_lfsr = 8'hA5;
    endtask

    task automatic model_step(input bit pb, input bit nb, input bit vb, input bit sd,
                              input logic [1:0] md);
        int  m;
        int  fwd;
        bit  playing;
        m = int'(md);
`ifndef MCU_PLAYLIST_SHUFFLE_EN
        if (m == 3) m = 0;
`endif
        fwd = (m == 3) ? shuffle_pick(m_song, m_lfsr) : (m_song + 1) % N;
        playing = (m_phase == 1);
        if (m_phase == 2) begin
            m_phase = m_run ? 1 : 0;
        end else if (nb != vb) begin
            m_run   = playing ^ pb;
            m_song  = nb ? fwd : (m_song + N - 1) % N;
            m_phase = 2;
        end else if (playing && sd) begin
            m_run   = 1'b1;
            m_phase = 2;
            if (m == 1) begin
                m_song = m_song;
            end else if (m == 2 && m_song == N - 1) begin
                m_song = 0;
                m_run  = 1'b0;
            end else begin
                m_song = fwd;
            end
        end else if (pb) begin
            m_phase = playing ? 0 : 1;
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // Drive one cycle of inputs at a negedge, then check outputs at the next negedge.
    task automatic cycle(input bit pb, input bit nb, input bit vb, input bit sd,
                         input logic [1:0] md);
        bus.play_button = pb;
        bus.next_button = nb;
        bus.prev_button = vb;
        bus.song_done   = sd;
        bus.mode        = md;
        model_step(pb, nb, vb, sd, md);
        @(negedge clk);
        check("play",         {31'd0, bus.play},         (m_phase == 1) ? 1 : 0);
        check("reset_player", {31'd0, bus.reset_player}, (m_phase == 2) ? 1 : 0);
        check("song",         32'(bus.song),             m_song);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.play_button = 0; bus.next_button = 0; bus.prev_button = 0;
        bus.song_done = 0; bus.mode = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_play", {31'd0, bus.play}, 0);
        check("rst_rp",   {31'd0, bus.reset_player}, 0);
        check("rst_song", 32'(bus.song), 0);
        reset = 1'b0;
        model_reset();
    endtask

    int hits[N];
    int repeats;
    int prev_song;
    logic [1:0] rmode;

    initial begin
        do_reset();

        // Play pressed in cycle 5 after reset release
        idle(4);
        cycle(1, 0, 0, 0, 2'd0);
        check("play_rise", {31'd0, bus.play}, 1);

        // Walk to song 3 while playing, then sequential wrap on song_done
        for (int i = 0; i < 3; i++) begin cycle(0, 1, 0, 0, 2'd0); idle(1); end
        cycle(0, 0, 0, 1, 2'd0);
        check("seq_wrap_song", 32'(bus.song), 0);
        check("seq_wrap_rp", {31'd0, bus.reset_player}, 1);
        check("seq_wrap_play_low", {31'd0, bus.play}, 0);
        idle(1);
        check("seq_wrap_resume", {31'd0, bus.play}, 1);

        // Paused prev wraps 0 -> 3; next+prev together does nothing
        cycle(1, 0, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 2'd0);
        check("prev_wrap_song", 32'(bus.song), 3);
        idle(1);
        check("prev_stay_paused", {31'd0, bus.play}, 0);
        cycle(0, 1, 1, 0, 2'd0);
        check("both_ignored", {31'd0, bus.reset_player}, 0);

        // To song 1 playing; song_done loses to next
        cycle(0, 1, 0, 0, 2'd0); idle(1);
        cycle(0, 1, 0, 0, 2'd0); idle(1);
        cycle(1, 0, 0, 0, 2'd0);
        cycle(0, 1, 0, 1, 2'd0);
        check("done_vs_next", 32'(bus.song), 2);
        idle(1);
        check("single_pulse", {31'd0, bus.reset_player}, 0);
        cycle(0, 0, 1, 0, 2'd0); idle(1);
        cycle(0, 0, 0, 1, 2'd1);
        check("repeat_one", 32'(bus.song), 1);
        idle(1);

        // STOP_AT_END at the last song stops after the switch
        cycle(0, 1, 0, 0, 2'd2); idle(1);
        cycle(0, 1, 0, 0, 2'd2); idle(1);
        cycle(0, 0, 0, 1, 2'd2);
        check("stop_end_song", 32'(bus.song), 0);
        idle(1);
        check("stop_end_play", {31'd0, bus.play}, 0);

        // Asynchronous reset in the middle of a switch
        cycle(0, 1, 0, 0, 2'd0);
        #1 reset = 1'b1;
        #1;
        check("arst_play", {31'd0, bus.play}, 0);
        check("arst_rp",   {31'd0, bus.reset_player}, 0);
        check("arst_song", 32'(bus.song), 0);
        @(negedge clk);
        do_reset();

        // Mode 3 run of next presses
        repeats = 0;
        for (int i = 0; i < N; i++) hits[i] = 0;
        for (int i = 0; i < 200; i++) begin
            prev_song = int'(bus.song);
            cycle(0, 1, 0, 0, 2'd3);
            check("song_range", (int'(bus.song) < N) ? 1 : 0, 1);
            if (int'(bus.song) == prev_song) repeats++;
            hits[int'(bus.song)]++;
`ifndef MCU_PLAYLIST_SHUFFLE_EN
            check("mode3_seq", 32'(bus.song), (prev_song + 1) % N);
`endif
            idle(1);
        end
        check("shuf_no_repeat", repeats, 0);
        for (int i = 0; i < N; i++) check("shuf_hit", (hits[i] > 0) ? 1 : 0, 1);

        // Random traffic
        rmode = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            bit pb, nb, vb, sd;
            if ($urandom_range(0, 40) == 0) rmode = 2'($urandom_range(0, 3));
            sd = ($urandom_range(0, 5) == 0);
            pb = !sd && ($urandom_range(0, 7) == 0);
            nb = ($urandom_range(0, 9) == 0);
            vb = ($urandom_range(0, 9) == 0);
            cycle(pb, nb, vb, sd, rmode);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
